// File: rtl/instr_fetch.sv
// Instruction fetch/issue sequencer.
// Reads instruction words and MVI immediates from a synchronous program ROM.
// Presents them to the control unit on ir/din, raises run, and holds it
// until done comes back. Owns the program counter, which wraps modulo 2^ADDR_W.
module instr_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              done,
  output logic [9:0]        ir,
  output logic [DATA_W-1:0] din,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_FETCH_IMM,
    S_LATCH_IMM,
    S_ISSUE,
    S_HALT
  } state_t;

  // Opcode field lives in bits 8:6 of the instruction word (III XXX YYY).
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t state;

  // The ROM sees the PC directly; its data returns one cycle later in LATCH*.
  assign mem_addr = pc;

  // Busy whenever a fetch or an issue is in flight.
  assign busy = (state != S_IDLE) && (state != S_HALT);

  // Sequencer: single registered FSM that also owns pc, ir, din, run and halted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      pc     <= '0;
      ir     <= '0;
      din    <= '0;
      run    <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end

        S_FETCH: begin
          pc    <= pc + ADDR_W'(1);
          state <= S_LATCH;
        end

        S_LATCH: begin
          ir <= mem_rdata[9:0];
          case (mem_rdata[8:6])
            OP_MVI:  state <= S_FETCH_IMM;
            OP_HALT: begin
              // HALT is consumed here and never reaches the control unit.
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              run   <= 1'b1;
              state <= S_ISSUE;
            end
          endcase
        end

        S_FETCH_IMM: begin
          pc    <= pc + ADDR_W'(1);
          state <= S_LATCH_IMM;
        end

        S_LATCH_IMM: begin
          din   <= mem_rdata;
          run   <= 1'b1;
          state <= S_ISSUE;
        end

        S_ISSUE: begin
          // start is deliberately not looked at here; done wins.
          if (done) begin
            run   <= 1'b0;
            state <= S_FETCH;
          end
        end

        S_HALT: begin
          // Restart always begins again from address 0.
          if (start) begin
            pc     <= '0;
            halted <= 1'b0;
            state  <= S_FETCH;
          end
        end

        default: begin
          run    <= 1'b0;
          halted <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a synchronous ROM model.
module tb_instr_fetch;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  logic              clock;
  logic              resetn;
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              done;
  logic [9:0]        ir;
  logic [DATA_W-1:0] din;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;

  logic [DATA_W-1:0] rom [0:31];

  int n_chk;
  int n_bad;

  instr_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .done      (done),
    .ir        (ir),
    .din       (din),
    .run       (run),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM: data for the address seen at an edge appears after it.
  always @(posedge clock) mem_rdata <= rom[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    resetn = 1'b0;
    start = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0] = 16'h000A;   // MV  0_000_001_010
    rom[1] = 16'h0058;   // MVI 0_001_011_000
    rom[2] = 16'h1234;   // immediate
    rom[3] = 16'h01C0;   // HALT 0_111_000_000

    step(); step();
    resetn = 1'b1;
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step(); step();
    chk("idle_pc", 32'(pc), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // ---- MV issue ----
    start = 1'b1;
    step();                       // FETCH (t)
    start = 1'b0;
    chk("mv_fetch_addr", 32'(mem_addr), 32'd0);
    chk("mv_fetch_busy", 32'(busy), 32'd1);
    chk("mv_fetch_run", 32'(run), 32'd0);
    step();                       // LATCH (t+1)
    chk("mv_latch_pc", 32'(pc), 32'd1);
    chk("mv_latch_run", 32'(run), 32'd0);
    step();                       // ISSUE (t+2)
    chk("mv_run1", 32'(run), 32'd1);
    chk("mv_ir", 32'(ir), 32'h00A);
    chk("mv_din_kept", 32'(din), 32'd0);
    step();
    chk("mv_run2", 32'(run), 32'd1);
    step();
    chk("mv_run3", 32'(run), 32'd1);
    done = 1'b1;
    step();                       // FETCH of address 1
    done = 1'b0;
    chk("mv_run_fall", 32'(run), 32'd0);
    chk("mv_next_addr", 32'(mem_addr), 32'd1);
    chk("mv_next_busy", 32'(busy), 32'd1);

    // ---- MVI issue ----
    step();                       // LATCH
    chk("mvi_latch_run", 32'(run), 32'd0);
    step();                       // FETCH_IMM
    chk("mvi_fimm_addr", 32'(mem_addr), 32'd2);
    chk("mvi_fimm_ir", 32'(ir), 32'h058);
    chk("mvi_fimm_run", 32'(run), 32'd0);
    step();                       // LATCH_IMM
    chk("mvi_limm_pc", 32'(pc), 32'd3);
    chk("mvi_limm_run", 32'(run), 32'd0);
    step();                       // ISSUE
    chk("mvi_run1", 32'(run), 32'd1);
    chk("mvi_din1", 32'(din), 32'h1234);
    chk("mvi_ir1", 32'(ir), 32'h058);
    step();
    chk("mvi_run2", 32'(run), 32'd1);
    chk("mvi_din2", 32'(din), 32'h1234);
    chk("mvi_ir2", 32'(ir), 32'h058);
    done = 1'b1;
    step();                       // FETCH of address 3
    done = 1'b0;
    chk("mvi_run_fall", 32'(run), 32'd0);
    chk("mvi_pc", 32'(pc), 32'd3);

    // ---- HALT ----
    step();                       // LATCH
    chk("halt_latch_run", 32'(run), 32'd0);
    step();                       // HALT
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_run", 32'(run), 32'd0);
    chk("halt_pc", 32'(pc), 32'd4);
    step(); step();
    chk("halt_stay", 32'(halted), 32'd1);
    chk("halt_stay_run", 32'(run), 32'd0);
    chk("halt_stay_pc", 32'(pc), 32'd4);
    start = 1'b1;
    step();                       // FETCH from 0
    start = 1'b0;
    chk("restart_pc", 32'(pc), 32'd0);
    chk("restart_addr", 32'(mem_addr), 32'd0);
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);

    // ---- spurious done during FETCH/LATCH ----
    done = 1'b1;
    step();                       // LATCH, done seen at FETCH edge
    chk("spur_latch_pc", 32'(pc), 32'd1);
    chk("spur_latch_run", 32'(run), 32'd0);
    step();                       // ISSUE, done seen at LATCH edge
    done = 1'b0;
    chk("spur_run1", 32'(run), 32'd1);
    chk("spur_ir", 32'(ir), 32'h00A);
    step();
    chk("spur_run2", 32'(run), 32'd1);
    chk("spur_din_kept", 32'(din), 32'h1234);

    // ---- asynchronous reset mid-ISSUE ----
    resetn = 1'b0;
    #1;
    chk("arst_run", 32'(run), 32'd0);
    chk("arst_ir", 32'(ir), 32'd0);
    chk("arst_din", 32'(din), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    step();
    resetn = 1'b1;
    step(); step(); step();
    chk("arst_idle_pc", 32'(pc), 32'd0);
    chk("arst_idle_busy", 32'(busy), 32'd0);
    chk("arst_idle_run", 32'(run), 32'd0);

    // ---- back-to-back with done tied high, wrap through all 32 words ----
    // Upper ROM bits are nonzero to show ir takes only bits 9:0; bit 9 set.
    for (int i = 0; i < 32; i++) rom[i] = 16'hA000 | 16'h0280 | 16'(i);
    done = 1'b1;
    start = 1'b1;                 // held high: ignored outside IDLE/HALT
    step();                       // FETCH of address 0
    for (int k = 0; k < 34; k++) begin
      chk($sformatf("b2b_addr_%0d", k), 32'(mem_addr), 32'(k % 32));
      chk($sformatf("b2b_frun_%0d", k), 32'(run), 32'd0);
      step();                     // LATCH
      chk($sformatf("b2b_pc_%0d", k), 32'(pc), 32'((k + 1) % 32));
      chk($sformatf("b2b_lrun_%0d", k), 32'(run), 32'd0);
      step();                     // ISSUE, single cycle
      chk($sformatf("b2b_run_%0d", k), 32'(run), 32'd1);
      chk($sformatf("b2b_ir_%0d", k), 32'(ir), 32'(10'h280 | 10'(k % 32)));
      step();                     // next FETCH
    end
    done = 1'b0;
    start = 1'b0;
    chk("b2b_end_run", 32'(run), 32'd0);
    chk("b2b_end_halted", 32'(halted), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch/issue sequencer that drives the processor control unit. Reads 10-bit instruction words (format III XXX YYY, opcode in bits 8:6) and MVI immediates from a synchronous program ROM, presents them on `ir` and `din`, raises `run`, and holds it until the control unit returns `done`. It sits between the program ROM and the control unit and owns the program counter.

## Interface

Parameters:
- DATA_W, 16, width of ROM words and of the `din` immediate bus.
- ADDR_W, 5, ROM address width; the PC wraps modulo 2^ADDR_W.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  begin execution from current PC; sampled in IDLE and HALT only.
- mem_addr  out  ADDR_W  ROM address; combinational, equals `pc`.
- mem_rdata  in  DATA_W  ROM data, valid the cycle after `mem_addr` is presented.
- done  in  1  control unit instruction-complete; honoured only in ISSUE.
- ir  out  10  instruction register, `mem_rdata[9:0]` of the fetched word.
- din  out  DATA_W  immediate operand for MVI.
- run  out  1  instruction valid and executing; registered.
- pc  out  ADDR_W  program counter.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.

## Operation

- Reset (resetn=0, any state, immediate): state IDLE, pc=0, ir=0, din=0, run=0, halted=0, busy=0.
- States: IDLE, FETCH, LATCH, FETCH_IMM, LATCH_IMM, ISSUE, HALT.
- IDLE: start=1 -> FETCH.
- FETCH: mem_addr=pc; pc<=pc+1; -> LATCH.
- LATCH: ir<=mem_rdata[9:0]. Decode mem_rdata[8:6]:
  - 001 (MVI) -> FETCH_IMM.
  - 111 (HALT) -> HALT. run stays 0. No issue.
  - otherwise -> ISSUE, run<=1.
- FETCH_IMM: mem_addr=pc; pc<=pc+1; -> LATCH_IMM.
- LATCH_IMM: din<=mem_rdata; run<=1; -> ISSUE.
- ISSUE: run held 1; ir and din stable. done=1 -> run<=0, go to FETCH.
- HALT: halted=1. start=1 -> pc<=0, halted<=0, go to FETCH.
- din retains its last value for non-MVI instructions.
- ir bit 9 is passed through unchanged.
- PC arithmetic: unsigned ADDR_W bits, 2^ADDR_W-1 + 1 = 0. There is no overflow flag.
- done outside ISSUE is ignored. start outside IDLE/HALT is ignored.

## Timing

- Non-MVI: FETCH at cycle t, LATCH t+1, run=1 from t+2.
- MVI: FETCH t, LATCH t+1, FETCH_IMM t+2, LATCH_IMM t+3, run=1 from t+4.
- The run high time is the number of cycles until done is sampled, minimum 1. run falls on the edge where done=1 is sampled in ISSUE.
- The next FETCH occupies the cycle immediately after run falls. Back-to-back issue overhead is 2 cycles for non-MVI and 4 cycles for MVI.
- Simultaneous done=1 and start=1 in ISSUE: done is honoured, start is ignored.
- Reset asserted mid-ISSUE: run drops asynchronously. After release the block waits in IDLE for start.

## Test plan

- Reset: assert resetn=0 mid-ISSUE -> run, ir, din, pc, halted all 0 immediately. After release, no fetch until start.
- MV issue: ROM[0]=10'b0_000_001_010, start, done returned 3 cycles after run rises -> ir=0x00A; run high from cycle 2 after FETCH for exactly 3 cycles; pc=1; next FETCH at address 1.
- MVI issue: ROM[1]=10'b0_001_011_000 and ROM[2]=0x1234 -> ir=0x058, din=0x1234 stable while run=1; run rises 4 cycles after FETCH; pc=3 after issue.
- HALT: ROM[3]=10'b0_111_000_000 -> halted=1, busy=0, run never asserted, pc=4. Pulse start -> pc=0, fetch restarts at address 0.
- Spurious done and wrap: pulse done during FETCH/LATCH -> no effect. Program fills all 32 words with non-HALT ops and done tied high -> pc wraps from 31 to 0 and execution continues.
- Back-to-back handshake: done held high continuously -> each non-MVI run pulse lasts exactly 1 cycle, with a 2-cycle gap between pulses.
